// File: rtl/piso_shift_register.sv
// piso_shift_register: MSB-first parallel-to-serial converter with ready/valid load.
// Define PARITY_EN to append an even-parity bit after din[0].
module piso_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last
);
    localparam int CW = $clog2(WIDTH);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_d;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             accept;

    assign load_ready = state == IDLE;
    assign accept     = load_ready && load_valid;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = load_valid ? SHIFT : IDLE;
`ifdef PARITY_EN
            SHIFT:   state_d = cnt == '0 ? PARITY : SHIFT;
            PARITY:  state_d = IDLE;
`else
            SHIFT:   state_d = cnt == '0 ? IDLE : SHIFT;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_d;

`ifdef PARITY_EN
    logic par;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)      par <= 1'b0;
        else if (accept) par <= ^din;
    assign sout_last = sout_valid && state == PARITY;
`else
    assign sout_last = sout_valid && state == SHIFT && cnt == '0;
`endif

    // sout is loaded with the next bit on the same edge the shift register advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            cnt        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
        end else if (accept) begin
            shreg      <= {din[WIDTH-2:0], 1'b0};
            cnt        <= CW'(WIDTH - 1);
            sout       <= din[WIDTH-1];
            sout_valid <= 1'b1;
        end else if (state == SHIFT && cnt != '0) begin
            shreg      <= {shreg[WIDTH-2:0], 1'b0};
            cnt        <= cnt - CW'(1);
            sout       <= shreg[WIDTH-1];
            sout_valid <= 1'b1;
`ifdef PARITY_EN
        end else if (state == SHIFT) begin
            sout       <= par;
            sout_valid <= 1'b1;
`endif
        end else begin
            sout       <= 1'b0;
            sout_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_piso_shift_register.sv
// tb_piso_shift_register: random and directed checks against a queue-of-frame-bits model.
module tb_piso_shift_register;
    localparam int W = 8;
    logic         clk = 1'b0, rst_n = 1'b0, load_valid = 1'b0;
    logic [W-1:0] din = '0;
    logic         load_ready, sout, sout_valid, sout_last;
    int           vectors = 0, errs = 0;
    logic         q[$];

    piso_shift_register #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
        .load_ready(load_ready), .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs follow directly from the bits still owed for the current frame.
    task automatic check_all();
        chk("load_ready", load_ready, q.size() == 0);
        chk("sout_valid", sout_valid, q.size() > 0);
        chk("sout", sout, q.size() > 0 ? q[0] : 1'b0);
        chk("sout_last", sout_last, q.size() == 1);
    endtask

    task automatic step(input logic lv, input logic [W-1:0] d);
        load_valid = lv;
        din = d;
        @(posedge clk);
        if (q.size() == 0 && lv) begin
            for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
`ifdef PARITY_EN
            q.push_back(^d);
`endif
        end else if (q.size() > 0) begin
            void'(q.pop_front());
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        q.delete();
        #1 check_all();
    endtask

    initial begin
        #3 check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        step(1'b0, 8'h3C);
        step(1'b1, 8'hA5);
        for (int i = 0; i < W + 2; i++) step(1'b0, 8'($urandom));
        step(1'b1, 8'h07);
        for (int i = 0; i < W + 2; i++) step(1'b1, 8'($urandom));
        step(1'b1, 8'h03);
        for (int i = 0; i < W + 2; i++) step(1'b0, 8'h00);
        for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), 8'($urandom));
        for (int i = 0; i < 60; i++) step(1'b1, 8'($urandom));
        while (q.size() > 0) step(1'b0, 8'h00);
        step(1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
        async_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        step(1'b1, 8'h81);
        for (int i = 0; i < W + 2; i++) step(1'b0, 8'h00);
        step(1'b1, 8'($urandom));
        step(1'b0, 8'h00);
        async_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h5A);
        for (int i = 0; i < W + 2; i++) step(1'b0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/piso_shift_register.md
PISO_SHIFT_REGISTER -- requirements
Module: piso_shift_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel data width in bits; legal values are 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port din, input, WIDTH bits: the parallel word to serialize.
REQ-005 The block SHALL have port load_valid, input, 1 bit: din holds a word to be accepted.
REQ-006 The block SHALL have port load_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 The block SHALL have port sout, output, 1 bit: the serial data bit.
REQ-008 The block SHALL have port sout_valid, output, 1 bit: sout carries a frame bit this cycle.
REQ-009 The block SHALL have port sout_last, output, 1 bit: the current sout bit is the final bit of the frame.

Function
REQ-010 The block SHALL implement FSM states IDLE and SHIFT, plus PARITY when PARITY_EN is defined.
REQ-011 load_ready SHALL be 1 exactly when the state is IDLE; it is decoded from registered state only, with no combinational path from load_valid.
REQ-012 A word SHALL be accepted on a rising edge where load_valid=1 and load_ready=1; din is captured into an internal shift register and the FSM moves IDLE->SHIFT.
REQ-013 In IDLE with load_valid=0 the FSM SHALL remain in IDLE, and din SHALL be ignored.
REQ-014 Changes on din and load_valid while not in IDLE SHALL have no effect on the frame in progress.
REQ-015 Bits SHALL be sent MSB first: din[WIDTH-1] in the first cycle after acceptance and din[0] in cycle WIDTH after acceptance.
REQ-016 sout and sout_valid SHALL be registered outputs: sout_valid=1 for every frame bit and 0 otherwise.
REQ-017 sout SHALL be 0 whenever sout_valid=0.
REQ-018 A WIDTH-wide-enough down-counter SHALL track the remaining bits: it loads WIDTH-1 on acceptance and decrements each SHIFT cycle.
REQ-019 SHIFT->IDLE SHALL occur on the edge after the data bit with count 0 is shown; with PARITY_EN defined, the FSM goes SHIFT->PARITY instead.
REQ-020 PARITY SHALL last exactly one cycle, then return to IDLE.
REQ-021 sout_last SHALL be 1 only during the final frame bit: din[0] without PARITY_EN, or the parity bit with PARITY_EN.
REQ-022 The minimum spacing between acceptances SHALL be WIDTH+1 cycles without PARITY_EN and WIDTH+2 cycles with it, because one IDLE cycle always separates frames.
REQ-023 The counter SHALL NOT wrap; the count-0 condition ends the SHIFT state.

Reset
REQ-024 On rst_n=0, the block SHALL immediately and asynchronously force state IDLE, shift register 0, counter 0, and parity accumulator 0.
REQ-025 During reset, the outputs SHALL be sout=0, sout_valid=0, sout_last=0, and load_ready=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no further valid bits; the first word after release is accepted normally.

Configuration
REQ-027 When macro PARITY_EN is defined, the block SHALL append one even-parity bit after din[0]: the XOR of all WIDTH captured bits, so the count of ones in the frame is even.
REQ-028 When PARITY_EN is undefined, the PARITY state, the parity logic and the extra frame cycle SHALL be absent, and a frame SHALL be exactly WIDTH bits long.

Verification
REQ-029 Reset check: assert rst_n=0 mid-cycle -> all outputs take their reset values before the next clk edge, and load_ready=1.
REQ-030 WIDTH=8, no PARITY_EN, din=8'hA5 accepted at edge N -> sout=1,0,1,0,0,1,0,1 with sout_valid=1 on cycles N+1..N+8, sout_last=1 only on N+8, and load_ready=1 again on N+9.
REQ-031 PARITY_EN, din=8'h07 -> 8 data bits 0,0,0,0,0,1,1,1, then parity bit 1 with sout_last=1 on cycle 9.
REQ-032 PARITY_EN, din=8'h03 -> parity bit 0 on cycle 9.
REQ-033 load_valid held at 1 with din changing every cycle -> only words present at IDLE edges are captured, and frames are separated by exactly one IDLE cycle.
REQ-034 rst_n pulsed low during bit 4 of din=8'hFF -> sout_valid drops at once; after release, din=8'h81 is sent correctly as 1,0,0,0,0,0,0,1.
